// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the shared 4:1 sampled-bit mux: one-hot grant, bounded
// hold time, registered data bit with a valid strobe and a timeout pulse.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] data,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       y,
    output logic       y_valid,
    output logic       preempt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             preempt_q, preempt_d;

    logic [1:0]       pick_idx;
    logic             owner_req;
    logic             last_sample;

    // Scan ptr, ptr+1, ... downwards so the smallest offset from ptr wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    assign pick_idx    = rr_pick(req, ptr_q);
    assign owner_req   = req[sel_q];
    assign last_sample = (hold_cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            sel_q      <= 2'd0;
            hold_cnt_q <= '0;
            gnt_q      <= 4'd0;
            y_q        <= 1'b0;
            y_valid_q  <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            preempt_q  <= preempt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req || last_sample) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every exit from GRANT hands lowest priority to the owner just served.
    always_comb begin
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        y_d        = y_q;
        y_valid_d  = 1'b0;
        preempt_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d      = 4'b0001 << pick_idx;
                    sel_d      = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    gnt_d = 4'd0;
                    ptr_d = sel_q + 2'd1;
                end else begin
                    y_d        = data[sel_q];
                    y_valid_d  = 1'b1;
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    if (last_sample) begin
                        gnt_d     = 4'd0;
                        ptr_d     = sel_q + 2'd1;
                        preempt_d = 1'b1;
                    end
                end
            end
            default: begin
                gnt_d = 4'd0;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign preempt = preempt_q;

endmodule
